// File: rtl/fifo_sync_flex.sv
// ---------------------------------------------------------------------------
// fifo_sync_flex
//
// Single-clock FIFO with an internal storage array, selectable standard or
// first-word-fall-through read mode, programmable almost-full/almost-empty
// thresholds and a registered occupancy count.
//
// Optional feature macro: FIFO_ERR_FLAG_EN
//   When defined, adds sticky overflow/underflow error flags and a clear
//   input. When undefined, those three ports and their logic are absent.
//
// Parameters:
//   WIDTH      data word width in bits
//   DEPTH_LOG  log2 of the depth (depth = 2**DEPTH_LOG words)
//   FWFT       0 = standard read, 1 = head word presented while not empty
//   AFULL_TH   fifo_almost_full asserts when count >= AFULL_TH
//   AEMPTY_TH  fifo_almost_empty asserts when count <= AEMPTY_TH
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous reset, active low
//   fifo_write_req     in   write request
//   fifo_write_data    in   write data [WIDTH]
//   fifo_full          out  no space, writes ignored
//   fifo_almost_full   out  count >= AFULL_TH
//   fifo_read_req      in   read / pop request
//   fifo_read_data     out  read data [WIDTH]
//   fifo_read_valid    out  fifo_read_data valid this cycle
//   fifo_empty         out  no data, reads ignored
//   fifo_almost_empty  out  count <= AEMPTY_TH
//   fifo_err_clr       in   (FIFO_ERR_FLAG_EN) clears the sticky error flags
//   fifo_overflow      out  (FIFO_ERR_FLAG_EN) write attempted while full
//   fifo_underflow     out  (FIFO_ERR_FLAG_EN) read attempted while empty
//   fifo_count         out  current occupancy [DEPTH_LOG+1], 0..2**DEPTH_LOG
// ---------------------------------------------------------------------------
module fifo_sync_flex #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8,
   parameter int FWFT      = 0,
   parameter int AFULL_TH  = 2**DEPTH_LOG - 2,
   parameter int AEMPTY_TH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_write_req,
   input  logic [WIDTH-1:0] fifo_write_data,
   output logic             fifo_full,
   output logic             fifo_almost_full,
   input  logic             fifo_read_req,
   output logic [WIDTH-1:0] fifo_read_data,
   output logic             fifo_read_valid,
   output logic             fifo_empty,
   output logic             fifo_almost_empty,
`ifdef FIFO_ERR_FLAG_EN
   input  logic             fifo_err_clr,
   output logic             fifo_overflow,
   output logic             fifo_underflow,
`endif
   output logic [DEPTH_LOG:0] fifo_count
);

   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam int CW    = DEPTH_LOG + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

   // Thresholds outside the representable occupancy range are configuration
   // errors and must stop elaboration rather than silently misbehave.
   if (AFULL_TH > DEPTH) begin : g_bad_afull
      $fatal(1, "fifo_sync_flex: AFULL_TH exceeds depth");
   end
   if (AEMPTY_TH >= DEPTH) begin : g_bad_aempty
      $fatal(1, "fifo_sync_flex: AEMPTY_TH must be below depth");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   logic [CW-1:0] wr_ptr;
   logic [CW-1:0] rd_ptr;
   logic [CW-1:0] wr_ptr_nxt;
   logic [CW-1:0] rd_ptr_nxt;
   logic [CW-1:0] cnt_nxt;
   logic          wr_acc;
   logic          rd_acc;

   // Acceptance is gated by the registered flags, so a full FIFO with both
   // requests only pops and an empty FIFO with both requests only pushes.
   // The next occupancy is the pointer distance; the wrap bit makes the
   // modular difference exact for 0..DEPTH.
   always_comb begin
      wr_acc     = fifo_write_req & ~fifo_full;
      rd_acc     = fifo_read_req & ~fifo_empty;
      wr_ptr_nxt = wr_ptr + CW'(wr_acc);
      rd_ptr_nxt = rd_ptr + CW'(rd_acc);
      cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;
   end

   // Pointers, count and all status flags are registered from the next-state
   // occupancy so they describe the contents right after each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fifo_count        <= '0;
         fifo_full         <= 1'b0;
         fifo_empty        <= 1'b1;
         fifo_almost_full  <= 1'b0;
         fifo_almost_empty <= 1'b1;
      end else begin
         wr_ptr            <= wr_ptr_nxt;
         rd_ptr            <= rd_ptr_nxt;
         fifo_count        <= cnt_nxt;
         fifo_full         <= (cnt_nxt == DEPTH_C);
         fifo_empty        <= (cnt_nxt == '0);
         fifo_almost_full  <= (cnt_nxt >= AFULL_C);
         fifo_almost_empty <= (cnt_nxt <= AEMPTY_C);
      end
   end

   // Storage array is deliberately left without reset; stale contents are
   // unreachable because the pointers are reset.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[DEPTH_LOG-1:0]] <= fifo_write_data;
      end
   end

   if (FWFT != 0) begin : g_fwft
      // Head word is presented combinationally; it is forced to zero while
      // empty so the output shows the reset value instead of stale memory.
      assign fifo_read_valid = ~fifo_empty;
      assign fifo_read_data  = fifo_empty ? '0 : mem[rd_ptr[DEPTH_LOG-1:0]];
   end else begin : g_std
      // Standard mode: the popped word is captured on the accepting edge,
      // valid for exactly one cycle, and the data register holds afterwards.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            fifo_read_data  <= '0;
            fifo_read_valid <= 1'b0;
         end else begin
            fifo_read_valid <= rd_acc;
            if (rd_acc) begin
               fifo_read_data <= mem[rd_ptr[DEPTH_LOG-1:0]];
            end
         end
      end
   end

`ifdef FIFO_ERR_FLAG_EN
   // Sticky error flags: a new error in the same cycle as a clear wins, so
   // an error event is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_overflow  <= 1'b0;
         fifo_underflow <= 1'b0;
      end else begin
         fifo_overflow  <= (fifo_write_req & fifo_full) |
                           (fifo_overflow & ~fifo_err_clr);
         fifo_underflow <= (fifo_read_req & fifo_empty) |
                           (fifo_underflow & ~fifo_err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flex
//
// Self-checking bench for fifo_sync_flex. Two instances (standard and FWFT
// mode, depth 4, AFULL_TH=3, AEMPTY_TH=1) are driven with directed vectors.
// A queue-based reference model tracks each FIFO and a compare process checks
// every output on every falling edge; directed literal checks pin the model.
// Error-flag scenarios are built only when FIFO_ERR_FLAG_EN is defined.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flex;

   localparam int W  = 8;
   localparam int DL = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;

   logic          w0 = 1'b0, r0 = 1'b0, w1 = 1'b0, r1 = 1'b0;
   logic [W-1:0]  d0 = '0, d1 = '0;

   logic          full0, afull0, valid0, empty0, aempty0;
   logic [W-1:0]  data0;
   logic [DL:0]   count0;
   logic          full1, afull1, valid1, empty1, aempty1;
   logic [W-1:0]  data1;
   logic [DL:0]   count1;
`ifdef FIFO_ERR_FLAG_EN
   logic          clr0 = 1'b0, clr1 = 1'b0;
   logic          ovf0, udf0, ovf1, udf1;
`endif

   int n_checks = 0;
   int n_passed = 0;

   always #5 clk = ~clk;

   fifo_sync_flex #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .fifo_write_req(w0), .fifo_write_data(d0),
      .fifo_full(full0), .fifo_almost_full(afull0),
      .fifo_read_req(r0), .fifo_read_data(data0), .fifo_read_valid(valid0),
      .fifo_empty(empty0), .fifo_almost_empty(aempty0),
`ifdef FIFO_ERR_FLAG_EN
      .fifo_err_clr(clr0), .fifo_overflow(ovf0), .fifo_underflow(udf0),
`endif
      .fifo_count(count0)
   );

   fifo_sync_flex #(.WIDTH(W), .DEPTH_LOG(DL), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .fifo_write_req(w1), .fifo_write_data(d1),
      .fifo_full(full1), .fifo_almost_full(afull1),
      .fifo_read_req(r1), .fifo_read_data(data1), .fifo_read_valid(valid1),
      .fifo_empty(empty1), .fifo_almost_empty(aempty1),
`ifdef FIFO_ERR_FLAG_EN
      .fifo_err_clr(clr1), .fifo_overflow(ovf1), .fifo_underflow(udf1),
`endif
      .fifo_count(count1)
   );

   // Reference model: plain queues of stored words, the standard-mode output
   // register, and sticky error bits.
   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];
   logic [W-1:0] m_data0 = '0;
   logic         m_valid0 = 1'b0;
   logic         m_ovf0 = 1'b0, m_udf0 = 1'b0, m_ovf1 = 1'b0, m_udf1 = 1'b0;
   logic         wa, ra, clr_a, clr_b;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
         m_data0  = '0;
         m_valid0 = 1'b0;
         m_ovf0 = 1'b0; m_udf0 = 1'b0; m_ovf1 = 1'b0; m_udf1 = 1'b0;
      end else begin
`ifdef FIFO_ERR_FLAG_EN
         clr_a = clr0;
         clr_b = clr1;
`else
         clr_a = 1'b0;
         clr_b = 1'b0;
`endif
         m_ovf0 = (w0 && q0.size() == 4) || (m_ovf0 && !clr_a);
         m_udf0 = (r0 && q0.size() == 0) || (m_udf0 && !clr_a);
         m_ovf1 = (w1 && q1.size() == 4) || (m_ovf1 && !clr_b);
         m_udf1 = (r1 && q1.size() == 0) || (m_udf1 && !clr_b);

         wa = w0 && q0.size() < 4;
         ra = r0 && q0.size() > 0;
         m_valid0 = ra;
         if (ra) m_data0 = q0.pop_front();
         if (wa) q0.push_back(d0);

         wa = w1 && q1.size() < 4;
         ra = r1 && q1.size() > 0;
         if (ra) void'(q1.pop_front());
         if (wa) q1.push_back(d1);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      checkOutput("m0.count",  32'(count0),  32'(q0.size()));
      checkOutput("m0.full",   32'(full0),   32'(q0.size() == 4));
      checkOutput("m0.empty",  32'(empty0),  32'(q0.size() == 0));
      checkOutput("m0.afull",  32'(afull0),  32'(q0.size() >= 3));
      checkOutput("m0.aempty", 32'(aempty0), 32'(q0.size() <= 1));
      checkOutput("m0.valid",  32'(valid0),  32'(m_valid0));
      checkOutput("m0.data",   32'(data0),   32'(m_data0));
      checkOutput("m1.count",  32'(count1),  32'(q1.size()));
      checkOutput("m1.full",   32'(full1),   32'(q1.size() == 4));
      checkOutput("m1.empty",  32'(empty1),  32'(q1.size() == 0));
      checkOutput("m1.afull",  32'(afull1),  32'(q1.size() >= 3));
      checkOutput("m1.aempty", 32'(aempty1), 32'(q1.size() <= 1));
      checkOutput("m1.valid",  32'(valid1),  32'(q1.size() > 0));
      checkOutput("m1.data",   32'(data1),   32'((q1.size() > 0) ? q1[0] : 8'h00));
`ifdef FIFO_ERR_FLAG_EN
      checkOutput("m0.ovf", 32'(ovf0), 32'(m_ovf0));
      checkOutput("m0.udf", 32'(udf0), 32'(m_udf0));
      checkOutput("m1.ovf", 32'(ovf1), 32'(m_ovf1));
      checkOutput("m1.udf", 32'(udf1), 32'(m_udf1));
`endif
   end

   // Drive one cycle of inputs (applied just after a falling edge) and return
   // at the next falling edge, after the rising edge has taken effect.
   task automatic applyStimulus(input logic iw0, input logic [W-1:0] id0, input logic ir0,
                                input logic iw1, input logic [W-1:0] id1, input logic ir1);
      w0 = iw0; d0 = id0; r0 = ir0;
      w1 = iw1; d1 = id1; r1 = ir1;
      @(negedge clk);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   logic [W-1:0] fill_vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      $display("[TB] start");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset state
      checkOutput("rst.count",  32'(count0),  0);
      checkOutput("rst.empty",  32'(empty0),  1);
      checkOutput("rst.aempty", 32'(aempty0), 1);
      checkOutput("rst.full",   32'(full0),   0);
      checkOutput("rst.valid",  32'(valid0),  0);
      checkOutput("rst.data",   32'(data0),   0);

      // 1: fill with 0x11..0x44
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, fill_vals[i], 1'b0, 1'b0, 8'h00, 1'b0);
         checkOutput("s1.count", 32'(count0), 32'(i + 1));
      end
      checkOutput("s1.full",  32'(full0),   1);
      checkOutput("s1.afull", 32'(afull0),  1);
      checkOutput("s1.aemp",  32'(aempty0), 0);
      idle();

      // 2: drain, standard-mode data arrives on the edge after the request
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
         checkOutput("s2.valid", 32'(valid0), 1);
         checkOutput("s2.data",  32'(data0),  32'(fill_vals[i]));
      end
      checkOutput("s2.empty", 32'(empty0), 1);
      idle();
      checkOutput("s2.vlow", 32'(valid0), 0);
      checkOutput("s2.hold", 32'(data0), 32'h44);

      // 3: full with simultaneous write/read -> read wins, write dropped
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_vals[i], 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("s3.data",  32'(data0),  32'h11);
      checkOutput("s3.count", 32'(count0), 3);
      checkOutput("s3.full",  32'(full0),  0);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
         checkOutput("s3.rd", 32'(data0), 32'(fill_vals[i]));
      end
      checkOutput("s3.empty", 32'(empty0), 1);
      idle();

      // 4: steady write+read at count 2 across pointer wrap
      applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b1, 8'(k + 2), 1'b1, 1'b0, 8'h00, 1'b0);
         checkOutput("s4.data",  32'(data0),  32'(k));
         checkOutput("s4.count", 32'(count0), 2);
      end
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("s4.tail", 32'(data0), 32'h0B);
      idle();

      // 5: FWFT write to empty, visible without a read request
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0);
      checkOutput("s5.valid", 32'(valid1), 1);
      checkOutput("s5.data",  32'(data1),  32'hA5);
      idle();
      checkOutput("s5.still", 32'(data1), 32'hA5);
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("s5.empty", 32'(empty1), 1);
      checkOutput("s5.vlow",  32'(valid1), 0);
      idle();

`ifdef FIFO_ERR_FLAG_EN
      // 6: sticky error flags and clear
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, fill_vals[i], 1'b0, 1'b0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("s6.ovf", 32'(ovf0), 1);
      idle();
      checkOutput("s6.ovfhold", 32'(ovf0), 1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
      checkOutput("s6.udf0", 32'(udf0), 0);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("s6.udf", 32'(udf0), 1);
      checkOutput("s6.udf1", 32'(udf1), 1);
      clr0 = 1'b1; clr1 = 1'b1;
      idle();
      clr0 = 1'b0; clr1 = 1'b0;
      checkOutput("s6.clrovf", 32'(ovf0), 0);
      checkOutput("s6.clrudf", 32'(udf0), 0);
      // Leave a flag set so the asynchronous reset has something to clear.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
`endif

      // Asynchronous reset in the middle of a write burst
      applyStimulus(1'b1, 8'hC1, 1'b0, 1'b1, 8'hD1, 1'b0);
      applyStimulus(1'b1, 8'hC2, 1'b1, 1'b1, 8'hD2, 1'b0);
      applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1, 8'hD3, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("ar.count0",  32'(count0),  0);
      checkOutput("ar.empty0",  32'(empty0),  1);
      checkOutput("ar.aempty0", 32'(aempty0), 1);
      checkOutput("ar.full0",   32'(full0),   0);
      checkOutput("ar.afull0",  32'(afull0),  0);
      checkOutput("ar.valid0",  32'(valid0),  0);
      checkOutput("ar.data0",   32'(data0),   0);
      checkOutput("ar.count1",  32'(count1),  0);
      checkOutput("ar.valid1",  32'(valid1),  0);
      checkOutput("ar.data1",   32'(data1),   0);
`ifdef FIFO_ERR_FLAG_EN
      checkOutput("ar.udf0", 32'(udf0), 0);
      checkOutput("ar.ovf0", 32'(ovf0), 0);
`endif
      w0 = 1'b0; r0 = 1'b0; w1 = 1'b0; r1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      // Data written before the reset must be gone.
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
      checkOutput("ar.novalid", 32'(valid0), 0);
      idle();

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
